// File: rtl/ecc_pkg.sv
// ecc_pkg: field constants and FSM state type for the GF(2^163) affine converter.
package ecc_pkg;
    localparam int ECC_M = 163;
    localparam int ECC_PAD_W = 176;
    localparam int ECC_CNT_W = 11;
    localparam logic [ECC_CNT_W-1:0] ECC_MAX_CYC = 11'd1024;
    localparam logic [ECC_M:0] ECC_F_POLY = (164'd1 << 163) | 164'hC9;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
endpackage

// File: rtl/gf2m_half.sv
// gf2m_half: combinational divide-by-x modulo the field polynomial.
module gf2m_half
    import ecc_pkg::*;
(
    input  logic [ECC_M-1:0] g,
    output logic [ECC_M-1:0] h
);
    logic [ECC_M:0] t;
    // Adding f makes an odd g even; the shifted-out bit is always zero.
    assign t = {1'b0, g} ^ (g[0] ? ECC_F_POLY : '0);
    assign h = t[ECC_M:1];
endmodule

// File: rtl/ecc_affine_conv.sv
// ecc_affine_conv: x = Xa / Za over GF(2^163) with a binary-Euclidean divider.
// Optional ECC_AFFINE_CYCCNT_EN adds cyc_cnt, the ITER cycles of the last conversion.
module ecc_affine_conv
    import ecc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [ECC_PAD_W-1:0] in_xa,
    input  logic [ECC_PAD_W-1:0] in_za,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ECC_PAD_W-1:0] out_x,
    output logic                 out_err
`ifdef ECC_AFFINE_CYCCNT_EN
    ,
    output logic [ECC_CNT_W-1:0] cyc_cnt
`endif
);
    localparam logic [ECC_M:0] U_ONE = 1;

    state_t state, state_n;
    logic [ECC_M:0] u, v, u_n, v_n;
    logic [ECC_M-1:0] g1, g2, g1_n, g2_n, g1_h, g2_h, x_r, x_n;
    logic [ECC_CNT_W-1:0] cnt, cnt_n;
    logic err_r, err_n;
    logic unused;

    assign unused = ^{in_xa[ECC_PAD_W-1:ECC_M], in_za[ECC_PAD_W-1:ECC_M]};

    gf2m_half u_half1 (.g(g1), .h(g1_h));
    gf2m_half u_half2 (.g(g2), .h(g2_h));

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out_x = {{(ECC_PAD_W-ECC_M){1'b0}}, x_r};
    assign out_err = err_r;

    always_comb begin
        state_n = state;
        u_n = u;
        v_n = v;
        g1_n = g1;
        g2_n = g2;
        cnt_n = cnt;
        x_n = x_r;
        err_n = err_r;
        case (state)
            IDLE: if (in_valid) begin
                state_n = LOAD;
                u_n = {1'b0, in_za[ECC_M-1:0]};
                v_n = ECC_F_POLY;
                g1_n = in_xa[ECC_M-1:0];
                g2_n = '0;
                cnt_n = '0;
                x_n = '0;
                err_n = 1'b0;
            end
            LOAD: begin
                state_n = u == '0 ? DONE : ITER;
                err_n = u == '0;
            end
            ITER: begin
                cnt_n = cnt + 11'd1;
                if (cnt_n == ECC_MAX_CYC) begin
                    state_n = DONE;
                    err_n = 1'b1;
                    x_n = '0;
                end else if (u == U_ONE) begin
                    state_n = DONE;
                    x_n = g1;
                end else if (v == U_ONE) begin
                    state_n = DONE;
                    x_n = g2;
                end else if (!u[0]) begin
                    u_n = u >> 1;
                    g1_n = g1_h;
                end else if (!v[0]) begin
                    v_n = v >> 1;
                    g2_n = g2_h;
                end else if (u >= v) begin
                    u_n = u ^ v;
                    g1_n = g1 ^ g2;
                end else begin
                    v_n = v ^ u;
                    g2_n = g2 ^ g1;
                end
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            u <= '0;
            v <= '0;
            g1 <= '0;
            g2 <= '0;
            cnt <= '0;
            x_r <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_n;
            u <= u_n;
            v <= v_n;
            g1 <= g1_n;
            g2 <= g2_n;
            cnt <= cnt_n;
            x_r <= x_n;
            err_r <= err_n;
        end
    end

`ifdef ECC_AFFINE_CYCCNT_EN
    logic [ECC_CNT_W-1:0] cyc_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_r <= '0;
        else if (state == IDLE && in_valid) cyc_r <= '0;
        else if (state != DONE && state_n == DONE) cyc_r <= cnt_n;
    end
    assign cyc_cnt = cyc_r;
`endif
endmodule
